adder_result_checker: RTL and testbench

Synthesizable receive-side checker for the 4-bit ripple adder (`fourBit`). It samples operand/result tuples presented with a valid strobe and recomputes the expected SUM/CO. It counts passes and failures and captures the first failing vector. It sits at the DUT output in self-check builds, so on-board runs report pass/fail without a simulator.

---
 rtl/adder_chk_pkg.sv | 22 ++
 rtl/adder_result_checker_ref.sv | 24 ++
 rtl/adder_result_checker.sv | 132 +++++++++++++
 tb/tb_adder_result_checker.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_chk_pkg.sv
// Shared types for the fourBit adder result checker: FSM state encoding
// and the tuple layout {a,b,ci,sum,co} for the native 4-bit adder width.
package adder_chk_pkg;

  localparam int CHK_WIDTH = 4;
  localparam int TUPLE_W   = 2*CHK_WIDTH + 2 + CHK_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [CHK_WIDTH-1:0] a;
    logic [CHK_WIDTH-1:0] b;
    logic                 ci;
    logic [CHK_WIDTH-1:0] sum;
    logic                 co;
  } tuple_t;

endpackage

// File: rtl/adder_result_checker_ref.sv
// Golden adder: purely combinational {co,sum} = a + b + ci, carried out at
// WIDTH+1 bits so the carry is never lost. Reusable by other checkers.
module adder_ref_model
  import adder_chk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  logic [WIDTH:0] total;

  // Zero-extended add keeps the carry as the top bit.
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    sum   = total[WIDTH-1:0];
    co    = total[WIDTH];
  end

endmodule

// File: rtl/adder_result_checker.sv
// Receive-side checker for the fourBit ripple adder. Accepts {a,b,ci,sum,co}
// tuples in RUN, recomputes the expected result in a 2-stage pipeline,
// counts passes/fails (saturating) and captures the first failing tuple.
// Optional build macro: ADDER_CHK_HALT_ON_FAIL_EN (first mismatch ends run).
module adder_result_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int NUM_VECTORS = 256,
  parameter int CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       vld,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic                       ci,
  input  logic [WIDTH-1:0]           sum,
  input  logic                       co,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [CNT_W-1:0]           pass_cnt,
  output logic [CNT_W-1:0]           fail_cnt,
  output logic [2*WIDTH+1+WIDTH:0]   first_fail,
  output logic                       res_vld,
  output logic                       res_ok
);

  localparam int TW = 2*WIDTH + 1 + WIDTH + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t            state_q, state_d;
  logic              accept;
  logic              vld_p1, vld_p2, ok_p2;
  logic [TW-1:0]     tup_p1;
  logic [WIDTH-1:0]  a_p1, b_p1, sum_p1, exp_sum;
  logic              ci_p1, co_p1, exp_co;
  logic              cmp_ok, last_p1, halt_p1, finish_p1;
  logic [CNT_W-1:0]  chk_cnt;

  assign accept = vld && (state_q == RUN);
  assign {a_p1, b_p1, ci_p1, sum_p1, co_p1} = tup_p1;

  adder_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a   (a_p1),
    .b   (b_p1),
    .ci  (ci_p1),
    .sum (exp_sum),
    .co  (exp_co)
  );

  assign cmp_ok  = ({exp_co, exp_sum} == {co_p1, sum_p1});
  assign last_p1 = vld_p1 && (chk_cnt == CNT_W'(NUM_VECTORS - 1));
`ifdef ADDER_CHK_HALT_ON_FAIL_EN
  assign halt_p1 = vld_p1 && !cmp_ok;
`else
  assign halt_p1 = 1'b0;
`endif
  assign finish_p1 = last_p1 || halt_p1;

  // Next-state logic: start always (re)enters RUN; RUN ends on the last or halting compare.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     if (finish_p1) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---- S1: register the accepted tuple ----
  always_ff @(posedge clk) begin
    if (accept) tup_p1 <= {a, b, ci, sum, co};
  end

  // ---- S2: compare, update counters/capture, flush S1 on leaving RUN ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      ok_p2      <= 1'b0;
      chk_cnt    <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      first_fail <= '0;
    end else if (start) begin
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      ok_p2      <= 1'b0;
      chk_cnt    <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      first_fail <= '0;
    end else begin
      vld_p1 <= accept && !finish_p1;
      vld_p2 <= vld_p1;
      ok_p2  <= vld_p1 && cmp_ok;
      if (vld_p1) begin
        chk_cnt <= chk_cnt + 1'b1;
        if (cmp_ok) begin
          pass_cnt <= sat_inc(pass_cnt);
        end else begin
          fail_cnt <= sat_inc(fail_cnt);
          if (fail_cnt == '0) first_fail <= tup_p1;
        end
      end
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign pass    = done && (fail_cnt == '0);
  assign res_vld = vld_p2;
  assign res_ok  = ok_p2;

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker (default parameters).
module tb_adder_result_checker;

  localparam int W  = 4;
  localparam int NV = 256;
  localparam int CW = 16;
  localparam int TW = 3*W + 2;

  logic          clk = 1'b0;
  logic          rst_n, start, vld, ci, co;
  logic [W-1:0]  a, b, sum;
  logic          busy, done, pass, res_vld, res_ok;
  logic [CW-1:0] pass_cnt, fail_cnt;
  logic [TW-1:0] first_fail;

  int n_tests = 0;
  int n_fail  = 0;

  adder_result_checker #(.WIDTH(W), .NUM_VECTORS(NV), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vld(vld),
    .a(a), .b(b), .ci(ci), .sum(sum), .co(co),
    .busy(busy), .done(done), .pass(pass),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail(first_fail),
    .res_vld(res_vld), .res_ok(res_ok)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] gold(input logic [3:0] x, input logic [3:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {4'b0, c};
  endfunction

  task automatic drive(input logic [3:0] ta, input logic [3:0] tbv, input logic tci,
                       input logic [3:0] ts, input logic tco);
    a = ta; b = tbv; ci = tci; sum = ts; co = tco; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; vld = 1'b0;
    a = '0; b = '0; ci = 1'b0; sum = '0; co = 1'b0;
    idle(2);
    n_tests++;
    if ({busy, done, pass, res_vld, res_ok, pass_cnt, fail_cnt, first_fail} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b pass=%b rv=%b ro=%b pc=%0d fc=%0d ff=%h, want all 0",
               busy, done, pass, res_vld, res_ok, pass_cnt, fail_cnt, first_fail);
    end
    rst_n = 1'b1;
    idle(2);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_sweep(input bit stuck);
    logic [4:0]    g;
    logic [3:0]    s;
    logic [CW-1:0] exp_pc, exp_fc;
    logic [TW-1:0] exp_ff;
    do_start();
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL sweep_busy: got %b want 1", busy); end
    for (int bi = 0; bi < 16; bi++) begin
      for (int ai = 0; ai < 16; ai++) begin
        g = gold(4'(ai), 4'(bi), 1'b0);
        s = g[3:0];
        if (stuck) s[2] = 1'b0;
        drive(4'(ai), 4'(bi), 1'b0, s, g[4]);
      end
    end
    exp_pc = stuck ? 16'd128 : 16'd256;
    exp_fc = stuck ? 16'd128 : 16'd0;
    exp_ff = stuck ? {4'd4, 4'd0, 1'b0, 4'd0, 1'b0} : '0;
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL sweep_done_early: got %b want 0", done); end
    idle(1);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL sweep_done: done=%b busy=%b want 1 0", done, busy);
    end
    n_tests++;
    if (res_vld !== 1'b1) begin n_fail++; $display("FAIL sweep_last_res_vld: got %b want 1", res_vld); end
    n_tests++;
    if (pass_cnt !== exp_pc || fail_cnt !== exp_fc) begin
      n_fail++; $display("FAIL sweep_counts: pc=%0d fc=%0d want %0d %0d", pass_cnt, fail_cnt, exp_pc, exp_fc);
    end
    n_tests++;
    if (pass !== !stuck) begin n_fail++; $display("FAIL sweep_pass: got %b want %b", pass, !stuck); end
    n_tests++;
    if (first_fail !== exp_ff) begin
      n_fail++; $display("FAIL sweep_first_fail: got %h want %h", first_fail, exp_ff);
    end
    for (int i = 0; i < 3; i++) drive(4'(i), 4'd1, 1'b0, 4'd0, 1'b0);
    idle(2);
    n_tests++;
    if (pass_cnt !== exp_pc || fail_cnt !== exp_fc || done !== 1'b1) begin
      n_fail++; $display("FAIL done_ignores_vld: pc=%0d fc=%0d done=%b want %0d %0d 1",
                         pass_cnt, fail_cnt, done, exp_pc, exp_fc);
    end
  endtask

  task automatic test_single();
    do_start();
    drive(4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b1);
    n_tests++;
    if (res_vld !== 1'b0) begin n_fail++; $display("FAIL single_early: res_vld=%b want 0", res_vld); end
    idle(1);
    n_tests++;
    if (res_vld !== 1'b1 || res_ok !== 1'b1) begin
      n_fail++; $display("FAIL single_ok: res_vld=%b res_ok=%b want 1 1", res_vld, res_ok);
    end
    idle(1);
    n_tests++;
    if (res_vld !== 1'b0) begin n_fail++; $display("FAIL single_pulse: res_vld=%b want 0", res_vld); end
    drive(4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b0);
    idle(1);
    n_tests++;
    if (res_vld !== 1'b1 || res_ok !== 1'b0) begin
      n_fail++; $display("FAIL single_bad: res_vld=%b res_ok=%b want 1 0", res_vld, res_ok);
    end
    n_tests++;
    if (pass_cnt !== 16'd1 || fail_cnt !== 16'd1) begin
      n_fail++; $display("FAIL single_counts: pc=%0d fc=%0d want 1 1", pass_cnt, fail_cnt);
    end
    n_tests++;
    if (first_fail !== {4'hF, 4'h1, 1'b1, 4'h1, 1'b0}) begin
      n_fail++; $display("FAIL single_first_fail: got %h want %h", first_fail, {4'hF, 4'h1, 1'b1, 4'h1, 1'b0});
    end
  endtask

  task automatic test_idle_gaps();
    logic [4:0] g;
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 5; i++) begin
      g = gold(4'(i), 4'd2, 1'b0);
      drive(4'(i), 4'd2, 1'b0, g[3:0], g[4]);
    end
    idle(2);
    n_tests++;
    if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_vld_ignored: pc=%0d fc=%0d busy=%b want 0 0 0", pass_cnt, fail_cnt, busy);
    end
    do_start();
    for (int i = 0; i < 20; i++) begin
      g = gold(4'(i % 16), 4'd3, i[0]);
      drive(4'(i % 16), 4'd3, i[0], g[3:0], g[4]);
      idle(i % 4);
    end
    idle(3);
    n_tests++;
    if (pass_cnt !== 16'd20 || fail_cnt !== 16'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL gaps_counts: pc=%0d fc=%0d busy=%b want 20 0 1", pass_cnt, fail_cnt, busy);
    end
  endtask

  task automatic test_restart();
    logic [4:0] g;
    do_start();
    for (int i = 0; i < 100; i++) begin
      g = gold(4'(i % 16), 4'((i / 16) % 16), 1'b0);
      drive(4'(i % 16), 4'((i / 16) % 16), 1'b0, g[3:0], g[4]);
    end
    a = 4'd1; b = 4'd1; ci = 1'b0; sum = 4'd2; co = 1'b0; vld = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; vld = 1'b0;
    n_tests++;
    if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || busy !== 1'b1 || res_vld !== 1'b0) begin
      n_fail++; $display("FAIL restart_clear: pc=%0d fc=%0d busy=%b rv=%b want 0 0 1 0",
                         pass_cnt, fail_cnt, busy, res_vld);
    end
    for (int i = 0; i < NV; i++) begin
      g = gold(4'(i % 16), 4'(i / 16), 1'b1);
      drive(4'(i % 16), 4'(i / 16), 1'b1, g[3:0], g[4]);
    end
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL restart_done_early: got %b want 0", done); end
    idle(1);
    n_tests++;
    if (done !== 1'b1 || pass_cnt !== 16'd256 || pass !== 1'b1) begin
      n_fail++; $display("FAIL restart_done: done=%b pc=%0d pass=%b want 1 256 1", done, pass_cnt, pass);
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] g;
    do_start();
    for (int i = 0; i < 50; i++) begin
      g = gold(4'(i % 16), 4'd5, 1'b0);
      drive(4'(i % 16), 4'd5, 1'b0, g[3:0], g[4]);
    end
    n_tests++;
    if (pass_cnt !== 16'd49) begin n_fail++; $display("FAIL async_pre: pc=%0d want 49", pass_cnt); end
    vld = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, pass, res_vld, res_ok, pass_cnt, fail_cnt, first_fail} !== '0) begin
      n_fail++; $display("FAIL async_reset: busy=%b done=%b rv=%b pc=%0d fc=%0d want all 0",
                         busy, done, res_vld, pass_cnt, fail_cnt);
    end
    vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL async_idle: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

`ifdef ADDER_CHK_HALT_ON_FAIL_EN
  task automatic test_halt();
    logic [4:0] g;
    do_start();
    for (int i = 0; i < 16; i++) begin
      g = gold(4'(i), 4'd7, 1'b0);
      drive(4'(i), 4'd7, 1'b0, g[3:0], (i == 10) ? ~g[4] : g[4]);
    end
    idle(2);
    n_tests++;
    if (done !== 1'b1 || pass_cnt !== 16'd10 || fail_cnt !== 16'd1 || pass !== 1'b0) begin
      n_fail++; $display("FAIL halt: done=%b pc=%0d fc=%0d pass=%b want 1 10 1 0",
                         done, pass_cnt, fail_cnt, pass);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sweep(1'b0);
`ifdef ADDER_CHK_HALT_ON_FAIL_EN
    test_halt();
`else
    test_sweep(1'b1);
`endif
    test_single();
    test_idle_gaps();
    test_restart();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
